// File: rtl/sram64_controller.sv
// sram64_controller: 32-bit word port onto a 64-bit asynchronous SRAM.
// Reads fetch a whole line and return one half. Writes read the line,
// merge the new word into it and write the line back. READY stalls the
// pipeline until the access completes.
// Optional feature macro: SRAM_LINE_BUF_EN (one-entry line buffer).
//
// state   | meaning
// IDLE    | waiting for a request; READY high only when none is pending
// RD_WAIT | SRAM address applied, waiting READ_WAIT cycles for the data
// WR      | SRAM_WE_N low, merged line driven onto SRAM_DQ for one cycle
// DONE    | access finished; READY high for exactly one cycle
module sram64_controller #(
  parameter int READ_WAIT = 2,
  parameter int BASE_ADDR = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ADDR,
  input  logic [31:0] WR_DATA,
  output logic [31:0] RD_DATA,
  output logic        READY,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [63:0] SRAM_DQ
);

  localparam int CNT_W = $clog2(READ_WAIT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      off;
  logic [31:0]      wr_data_q;
  logic             op_wr_q;
  logic             hs_q;
  logic [63:0]      line_q;
  logic             req;
  logic             cnt_tc;
  logic             buf_hit;
  logic             unused_off;

  // Only off[18:2] matters; upper bits are outside the SRAM and [1:0] are byte lanes.
  assign off        = ADDR - 32'(BASE_ADDR);
  assign unused_off = ^{off[31:19], off[1:0]};
  assign req        = MEM_R_EN | MEM_W_EN;
  assign cnt_tc     = (cnt == CNT_W'(READ_WAIT - 1));

  function automatic logic [63:0] merge_half(input logic [63:0] line,
                                             input logic        hs,
                                             input logic [31:0] word);
    merge_half = hs ? {word, line[31:0]} : {line[63:32], word};
  endfunction

`ifdef SRAM_LINE_BUF_EN
  logic        buf_vld;
  logic [15:0] buf_idx;
  logic [63:0] buf_line;

  assign buf_hit = buf_vld && (buf_idx == off[18:3]);

  // Line buffer: refilled on every SRAM read capture, kept coherent on every write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_vld  <= 1'b0;
      buf_idx  <= '0;
      buf_line <= '0;
    end else if (state == RD_WAIT && cnt_tc) begin
      buf_vld  <= 1'b1;
      buf_idx  <= SRAM_ADDR[16:1];
      buf_line <= SRAM_DQ;
    end else if (state == WR) begin
      buf_line <= line_q;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake/strobe outputs; write wins when both enables are high.
  always_comb begin
    state_nxt = state;
    READY     = 1'b0;
    SRAM_WE_N = 1'b1;
    case (state)
      IDLE: begin
        READY = ~req;
        if (req) begin
          if (buf_hit) state_nxt = MEM_W_EN ? WR : DONE;
          else         state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt_tc) state_nxt = op_wr_q ? WR : DONE;
      WR: begin
        SRAM_WE_N = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        READY     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The data bus is only ever driven during the write cycle.
  assign SRAM_DQ = (state == WR) ? line_q : {64{1'bz}};

  // Request latch, settle counter, line capture/merge and read-data register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      SRAM_ADDR <= '0;
      RD_DATA   <= '0;
      wr_data_q <= '0;
      op_wr_q   <= 1'b0;
      hs_q      <= 1'b0;
      line_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_wr_q   <= MEM_W_EN;
          hs_q      <= off[2];
          wr_data_q <= WR_DATA;
          SRAM_ADDR <= {off[18:3], 1'b0};
          cnt       <= '0;
`ifdef SRAM_LINE_BUF_EN
          if (buf_hit) begin
            if (MEM_W_EN) line_q  <= merge_half(buf_line, off[2], WR_DATA);
            else          RD_DATA <= off[2] ? buf_line[63:32] : buf_line[31:0];
          end
`endif
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt_tc) begin
            if (op_wr_q) begin
              line_q <= merge_half(SRAM_DQ, hs_q, wr_data_q);
            end else begin
              line_q  <= SRAM_DQ;
              RD_DATA <= hs_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
